// File: rtl/dram_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// dram_sequencer_pkg
// Shared definitions for the slot-3 DRAM sequencer: the one-hot FSM state
// encoding, the address-mux select codes and small width helpers.
// ---------------------------------------------------------------------------
package dram_sequencer_pkg;

    // One-hot so that each strobe decodes from a single state bit.
    typedef enum logic [5:0] {
        IDLE  = 6'b000001,
        C_RAS = 6'b000010,
        C_COL = 6'b000100,
        C_CAS = 6'b001000,
        R_RAS = 6'b010000,
        PRE   = 6'b100000
    } state_t;

    localparam logic [1:0] ADDR_SEL_ROW  = 2'd0;
    localparam logic [1:0] ADDR_SEL_COL  = 2'd1;
    localparam logic [1:0] ADDR_SEL_RFSH = 2'd2;

    // Bits needed to hold the values 0..max_val (at least one bit).
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dram_sequencer_refresh.sv
// ---------------------------------------------------------------------------
// refresh_scheduler
// Free-running refresh timer, saturating backlog of owed refreshes and the
// RAS-only refresh row counter.
//   clk           system clock
//   rst           synchronous reset, active high
//   take          sequencer is starting a refresh this cycle (enters R_RAS)
//   pending_any   at least one refresh is owed
//   pending_full  backlog is at its limit; refresh must preempt the CPU
//   refresh_row   row to present during the refresh
// ---------------------------------------------------------------------------
module refresh_scheduler
    import dram_sequencer_pkg::*;
#(
    parameter int ROW_W            = 7,
    parameter int REFRESH_INTERVAL = 64,
    parameter int MAX_PENDING      = 4,
    parameter int TRAS             = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             take,
    output logic             pending_any,
    output logic             pending_full,
    output logic [ROW_W-1:0] refresh_row
);

    localparam int TIMER_W  = cnt_w(REFRESH_INTERVAL - 1);
    localparam int PEND_W   = cnt_w(MAX_PENDING);
    localparam int ROWCNT_W = cnt_w(TRAS);

    logic [TIMER_W-1:0]  timer;
    logic [PEND_W-1:0]   pending;
    logic [ROWCNT_W-1:0] row_cnt;
    logic                wrap;

    assign wrap         = (timer == TIMER_W'(REFRESH_INTERVAL - 1));
    assign pending_any  = (pending != '0);
    assign pending_full = (pending == PEND_W'(MAX_PENDING));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer       <= '0;
            pending     <= '0;
            row_cnt     <= '0;
            refresh_row <= '0;
        end else begin
            timer <= wrap ? '0 : timer + 1'b1;

            // A new request and a refresh start in the same cycle cancel.
            if (wrap && !take) begin
                if (!pending_full)
                    pending <= pending + 1'b1;
            end else if (take && !wrap) begin
                pending <= pending - 1'b1;
            end

            // The row must stay stable for the whole refresh, so it advances
            // on the edge that ends R_RAS: TRAS edges after the one taking it.
            if (take) begin
                row_cnt <= ROWCNT_W'(TRAS);
            end else if (row_cnt != '0) begin
                row_cnt <= row_cnt - 1'b1;
                if (row_cnt == ROWCNT_W'(1))
                    refresh_row <= refresh_row + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dram_sequencer.sv
// ---------------------------------------------------------------------------
// dram_sequencer
// RAS/CAS/WE sequencing for the 4164-class RAM behind slot 3. Arbitrates the
// array between Z80 accesses and RAS-only refresh; all strobes are registered
// decodes of the next FSM state.
//   clk, rst       system clock, synchronous active-high reset
//   nmreq          Z80 memory request (active low)
//   nsltsl3        slot 3 select (active low)
//   nrd, nwr       Z80 read / write strobes (active low)
//   nras, ncas     DRAM row / column strobes (active low)
//   nwe            DRAM write enable (active low)
//   addr_sel       address mux: 0 CPU row, 1 CPU column, 2 refresh row
//   refresh_row    row presented while addr_sel = 2
//   nwait          Z80 wait (active low)
// ---------------------------------------------------------------------------
module dram_sequencer
    import dram_sequencer_pkg::*;
#(
    parameter int ROW_W            = 7,
    parameter int REFRESH_INTERVAL = 64,
    parameter int MAX_PENDING      = 4,
    parameter int TRCD             = 2,
    parameter int TRAS             = 4,
    parameter int TRP              = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             nmreq,
    input  logic             nsltsl3,
    input  logic             nrd,
    input  logic             nwr,
    output logic             nras,
    output logic             ncas,
    output logic             nwe,
    output logic [1:0]       addr_sel,
    output logic [ROW_W-1:0] refresh_row,
    output logic             nwait
);

    localparam int PH_W = cnt_w(max3(TRCD, TRAS, TRP) - 1);

    state_t          state, next_state;
    logic [PH_W-1:0] phase;
    logic            served;
    logic            req, take;
    logic            pending_any, pending_full;
    logic            nras_d, ncas_d, nwe_d, nwait_d;
    logic [1:0]      addr_sel_d;

    // served blocks a second DRAM cycle inside one Z80 memory cycle.
    assign req  = !nmreq && !nsltsl3 && (!nrd || !nwr) && !served;
    assign take = (state == IDLE) && (next_state == R_RAS);

    refresh_scheduler #(
        .ROW_W            (ROW_W),
        .REFRESH_INTERVAL (REFRESH_INTERVAL),
        .MAX_PENDING      (MAX_PENDING),
        .TRAS             (TRAS)
    ) u_refresh (
        .clk          (clk),
        .rst          (rst),
        .take         (take),
        .pending_any  (pending_any),
        .pending_full (pending_full),
        .refresh_row  (refresh_row)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (pending_full)     next_state = R_RAS;
                else if (req)         next_state = C_RAS;
                else if (pending_any) next_state = R_RAS;
            end
            // nmreq rising before CAS is an aborted cycle: precharge, no CAS.
            C_RAS: begin
                if (nmreq)                           next_state = PRE;
                else if (phase == PH_W'(TRCD - 1))   next_state = C_COL;
            end
            C_COL:   next_state = nmreq ? PRE : C_CAS;
            C_CAS:   if (nmreq) next_state = PRE;
            R_RAS:   if (phase == PH_W'(TRAS - 1)) next_state = PRE;
            PRE:     if (phase == PH_W'(TRP - 1))  next_state = IDLE;
            default: next_state = IDLE;
        endcase

        nras_d     = 1'b1;
        ncas_d     = 1'b1;
        nwe_d      = 1'b1;
        addr_sel_d = ADDR_SEL_ROW;
        case (next_state)
            C_RAS: nras_d = 1'b0;
            C_COL: begin
                nras_d     = 1'b0;
                addr_sel_d = ADDR_SEL_COL;
            end
            C_CAS: begin
                nras_d     = 1'b0;
                ncas_d     = 1'b0;
                nwe_d      = nwr;
                addr_sel_d = ADDR_SEL_COL;
            end
            R_RAS: begin
                nras_d     = 1'b0;
                addr_sel_d = ADDR_SEL_RFSH;
            end
            default: ;
        endcase

        // Wait only a CPU that is being held off; the access already in
        // C_RAS/C_COL/C_CAS is never waited on.
        nwait_d = nwait;
        if (state == IDLE && next_state == C_RAS)
            nwait_d = 1'b1;
        else if (req && (state == R_RAS || state == PRE || take))
            nwait_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            phase    <= '0;
            served   <= 1'b0;
            nras     <= 1'b1;
            ncas     <= 1'b1;
            nwe      <= 1'b1;
            addr_sel <= ADDR_SEL_ROW;
            nwait    <= 1'b1;
        end else begin
            state    <= next_state;
            phase    <= (next_state != state) ? '0 : phase + 1'b1;
            nras     <= nras_d;
            ncas     <= ncas_d;
            nwe      <= nwe_d;
            addr_sel <= addr_sel_d;
            nwait    <= nwait_d;
            if (nmreq)
                served <= 1'b0;
            else if (next_state == C_CAS && state != C_CAS)
                served <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dram_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dram_sequencer
// Directed bench for dram_sequencer. An activity-level model (idle / CPU
// access / refresh / precharge, each timed by elapsed cycles) predicts every
// output and is compared on each falling edge; literal expectations at
// hand-computed edges pin the model. Edge numbers count rising edges after
// the last reset edge.
// ---------------------------------------------------------------------------
module tb_dram_sequencer;

    localparam int ROW_W            = 7;
    localparam int REFRESH_INTERVAL = 64;
    localparam int MAX_PENDING      = 4;
    localparam int TRCD             = 2;
    localparam int TRAS             = 4;
    localparam int TRP              = 2;
    localparam int ROWS             = 1 << ROW_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             nmreq = 1'b1, nsltsl3 = 1'b1, nrd = 1'b1, nwr = 1'b1;
    logic             nras, ncas, nwe, nwait;
    logic [1:0]       addr_sel;
    logic [ROW_W-1:0] refresh_row;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    dram_sequencer #(
        .ROW_W            (ROW_W),
        .REFRESH_INTERVAL (REFRESH_INTERVAL),
        .MAX_PENDING      (MAX_PENDING),
        .TRCD             (TRCD),
        .TRAS             (TRAS),
        .TRP              (TRP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .nmreq       (nmreq),
        .nsltsl3     (nsltsl3),
        .nrd         (nrd),
        .nwr         (nwr),
        .nras        (nras),
        .ncas        (ncas),
        .nwe         (nwe),
        .addr_sel    (addr_sel),
        .refresh_row (refresh_row),
        .nwait       (nwait)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", name, cyc, got, want);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_CPU, M_RFSH, M_PRE} act_t;
    act_t       m_act = M_IDLE;
    int         m_t = 0, m_pend = 0, m_tick = 0, m_row = 0;
    bit         m_served = 0, model_valid = 0;
    logic       e_nras = 1, e_ncas = 1, e_nwe = 1, e_nwait = 1;
    logic [1:0] e_addr = 0;

    always @(posedge clk) begin : model
        bit m_req, wrap, start_cpu, start_rfsh, into_cas;
        if (rst) begin
            m_act = M_IDLE; m_t = 0; m_pend = 0; m_tick = 0; m_row = 0;
            m_served = 0; e_nwait = 1; model_valid = 1;
        end else if (model_valid) begin
            m_req = !nmreq && !nsltsl3 && (!nrd || !nwr) && !m_served;
            wrap  = (m_tick == REFRESH_INTERVAL - 1);
            start_cpu = 0; start_rfsh = 0; into_cas = 0;
            if (m_act == M_IDLE) begin
                if (m_pend == MAX_PENDING) start_rfsh = 1;
                else if (m_req)            start_cpu  = 1;
                else if (m_pend > 0)       start_rfsh = 1;
            end
            if (start_cpu) e_nwait = 1;
            else if (m_req && (m_act == M_RFSH || m_act == M_PRE || start_rfsh)) e_nwait = 0;

            if (wrap && !start_rfsh) m_pend = (m_pend < MAX_PENDING) ? m_pend + 1 : MAX_PENDING;
            else if (start_rfsh && !wrap) m_pend = m_pend - 1;
            m_tick = wrap ? 0 : m_tick + 1;

            case (m_act)
                M_IDLE: begin
                    if (start_cpu)       begin m_act = M_CPU;  m_t = 0; end
                    else if (start_rfsh) begin m_act = M_RFSH; m_t = 0; end
                end
                M_CPU: begin
                    if (nmreq) begin m_act = M_PRE; m_t = 0; end
                    else begin into_cas = (m_t == TRCD); m_t++; end
                end
                M_RFSH: begin
                    if (m_t == TRAS - 1) begin
                        m_act = M_PRE; m_t = 0; m_row = (m_row + 1) % ROWS;
                    end else m_t++;
                end
                M_PRE: begin
                    if (m_t == TRP - 1) begin m_act = M_IDLE; m_t = 0; end
                    else m_t++;
                end
                default: ;
            endcase
            if (nmreq) m_served = 0;
            else if (into_cas) m_served = 1;
        end
        // Strobes follow the activity and time spent in it.
        e_nras = 1; e_ncas = 1; e_nwe = 1; e_addr = 0;
        if (m_act == M_CPU) begin
            e_nras = 0;
            if (m_t >= TRCD) e_addr = 1;
            if (m_t > TRCD) begin e_ncas = 0; e_nwe = nwr; end
        end else if (m_act == M_RFSH) begin
            e_nras = 0; e_addr = 2;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("nras", nras, e_nras);
            check("ncas", ncas, e_ncas);
            check("nwe", nwe, e_nwe);
            check("addr_sel", addr_sel, e_addr);
            check("nwait", nwait, e_nwait);
            check("refresh_row", refresh_row, m_row);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_until(input int n);
        while (cyc < n) step();
    endtask

    task automatic bus(input logic mreq, input logic sl, input logic rd, input logic wr);
        nmreq = mreq; nsltsl3 = sl; nrd = rd; nwr = wr;
    endtask

    initial begin
        bus(1, 1, 1, 1);
        rst = 1;
        step(); step();
        rst = 0; cyc = 0;
        check("rst nras", nras, 1);
        check("rst ncas", ncas, 1);
        check("rst nwe", nwe, 1);
        check("rst addr_sel", addr_sel, 0);
        check("rst nwait", nwait, 1);
        check("rst row", refresh_row, 0);

        // First refresh: owed at edge 64, R_RAS from edge 65, row advances at 69.
        run_until(63); check("idle63 nras", nras, 1);
        run_until(64); check("idle64 nras", nras, 1);
        run_until(65);
        check("rfsh nras", nras, 0);
        check("rfsh addr_sel", addr_sel, 2);
        check("rfsh row during", refresh_row, 0);
        run_until(69);
        check("rfsh row after", refresh_row, 1);
        check("rfsh pre nras", nras, 1);

        // Read: nras at 81, column at 83, ncas at 84.
        run_until(80); bus(0, 0, 0, 1);
        run_until(81); check("rd nras", nras, 0); check("rd row sel", addr_sel, 0);
        run_until(83); check("rd col sel", addr_sel, 1); check("rd ncas early", ncas, 1);
        run_until(84); check("rd ncas", ncas, 0); check("rd nwe", nwe, 1);
        run_until(86); bus(1, 1, 1, 1);
        run_until(87);
        check("rd end nras", nras, 1); check("rd end ncas", ncas, 1); check("rd nwait", nwait, 1);

        // Write, plus a re-select inside the same nmreq-low window.
        run_until(92); bus(0, 0, 1, 0);
        run_until(96); check("wr ncas", ncas, 0); check("wr nwe", nwe, 0);
        run_until(97); nsltsl3 = 1;
        run_until(98); nsltsl3 = 0;
        run_until(99); check("wr held ncas", ncas, 0); check("wr held nwe", nwe, 0);
        bus(1, 1, 1, 1);
        run_until(100); check("wr end nwe", nwe, 1); check("wr end ncas", ncas, 1);

        // Aborted cycle: nmreq rises during C_RAS.
        run_until(105); bus(0, 0, 0, 1);
        run_until(106); check("abort nras", nras, 0);
        bus(1, 1, 1, 1);
        run_until(107); check("abort nras off", nras, 1); check("abort ncas", ncas, 1);

        // Request during refresh (R_RAS 129..132, PRE 133..134, C_RAS at 136).
        run_until(129); check("r2 addr_sel", addr_sel, 2);
        bus(0, 0, 0, 1);
        run_until(130); check("r2 nwait low", nwait, 0);
        run_until(135); check("r2 nwait still", nwait, 0);
        run_until(136); check("r2 nwait high", nwait, 1); check("r2 cpu nras", nras, 0);
        check("r2 cpu row sel", addr_sel, 0);
        run_until(139); check("r2 ncas", ncas, 0);
        run_until(140); bus(1, 1, 1, 1);
        run_until(141); check("r2 end nras", nras, 1);

        // Backlog saturates behind a long access, then refresh preempts the CPU.
        run_until(150); bus(0, 0, 0, 1);
        run_until(154); check("sat ncas", ncas, 0);
        run_until(400); nmreq = 1;
        run_until(401); nmreq = 0;
        run_until(402); check("sat nwait pre", nwait, 0);
        run_until(404); check("sat rfsh first", addr_sel, 2); check("sat nwait", nwait, 0);
        run_until(411); check("sat cpu nras", nras, 0); check("sat cpu sel", addr_sel, 0);
        check("sat cpu nwait", nwait, 1);
        run_until(414); check("sat cpu ncas", ncas, 0);
        run_until(416); bus(1, 1, 1, 1);
        run_until(417); check("sat end nras", nras, 1);

        // Reset in the middle of C_CAS.
        run_until(500); bus(0, 0, 1, 0);
        run_until(505); check("rst cas ncas", ncas, 0);
        rst = 1;
        step();
        check("midrst nras", nras, 1); check("midrst ncas", ncas, 1);
        check("midrst nwe", nwe, 1); check("midrst row", refresh_row, 0);
        rst = 0; cyc = 0;
        bus(1, 1, 1, 1);

        // 128 refreshes wrap the row counter from 127 back to 0.
        run_until(REFRESH_INTERVAL * 127 + 5); check("row 127", refresh_row, 127);
        run_until(REFRESH_INTERVAL * 128 + 5); check("row wrap", refresh_row, 0);
        run_until(REFRESH_INTERVAL * 128 + 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
